// File: rtl/fm_fetch_pkg.sv
// Shared types and default sizes for the feature-map fetch unit.
package fm_fetch_pkg;

    localparam int FM_DATA_W     = 16;
    localparam int FM_ADDR_W     = 20;
    localparam int FM_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fetch_state_e;

    typedef struct packed {
        logic [FM_ADDR_W-1:0] base_addr;
        logic [7:0]           row_len;
        logic [7:0]           n_rows;
        logic [FM_ADDR_W-1:0] row_stride;
    } tile_desc_t;

endpackage

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO with occupancy count.
module fetch_fifo
    import fm_fetch_pkg::*;
#(
    parameter int DATA_W = FM_DATA_W,
    parameter int DEPTH  = FM_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [DATA_W-1:0]      din,
    input  logic                   pop,
    output logic [DATA_W-1:0]      dout,
    output logic [$clog2(DEPTH):0] cnt,
    output logic                   empty
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_q;
    logic [AW-1:0]     rd_q;
    logic [AW:0]       cnt_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + AW'(1);
            if (pop)  rd_q <= rd_q + AW'(1);
            cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    assign dout  = mem_q[rd_q];
    assign cnt   = cnt_q;
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/fm_fetch_unit.sv
// 2-D tile prefetcher serving single-word reads from feature-map memory.
// Define FM_FETCH_ERR_EN to add the sticky protocol-error output err.
module fm_fetch_unit
    import fm_fetch_pkg::*;
#(
    parameter int DATA_W     = FM_DATA_W,
    parameter int ADDR_W     = FM_ADDR_W,
    parameter int FIFO_DEPTH = FM_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [7:0]        row_len,
    input  logic [7:0]        n_rows,
    input  logic [ADDR_W-1:0] row_stride,
    output logic              busy,
    output logic              done,
    input  logic              r_req,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_value,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef FM_FETCH_ERR_EN
    ,
    output logic              err
`endif
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_e      state_q, state_d;
    tile_desc_t        desc_q;
    logic [7:0]        col_q, row_q;
    logic [ADDR_W-1:0] row_off_q;
    logic [CW-1:0]     outst_q, fifo_cnt;
    logic [15:0]       total_q, deliv_q;
    logic              pend_q, done_q, r_valid_q;
    logic [DATA_W-1:0] r_value_q, fifo_head;
    logic              fifo_empty, active, start_ok, zero_tile;
    logic              gnt_ok, rv_ok, last_col, last_row;
    logic              req_ok, svc, pop, last_pop;

    assign active    = (state_q == ISSUE) || (state_q == DRAIN);
    assign start_ok  = start && (state_q == IDLE);
    assign zero_tile = (row_len == 8'd0) || (n_rows == 8'd0);

    // Credit rule: never have more words in flight than free FIFO slots.
    assign mem_req = (state_q == ISSUE) &&
                     (({1'b0, fifo_cnt} + {1'b0, outst_q}) <
                      (CW+1)'(FIFO_DEPTH));
    assign mem_addr = (state_q == ISSUE) ?
                      ADDR_W'(desc_q.base_addr) + row_off_q +
                      ADDR_W'(col_q) : '0;

    assign gnt_ok   = mem_req && mem_gnt;
    assign rv_ok    = mem_rvalid && (outst_q != '0);
    assign last_col = (col_q == desc_q.row_len - 8'd1);
    assign last_row = (row_q == desc_q.n_rows - 8'd1);
    assign req_ok   = r_req && active && !pend_q &&
                      (deliv_q != total_q);
    assign svc      = pend_q || req_ok;
    assign pop      = svc && !fifo_empty;
    assign last_pop = pop && (deliv_q == total_q - 16'd1);

    assign busy    = (state_q != IDLE);
    assign done    = done_q;
    assign r_valid = r_valid_q;
    assign r_value = r_value_q;

    fetch_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (rv_ok),
        .din  (mem_rdata),
        .pop  (pop),
        .dout (fifo_head),
        .cnt  (fifo_cnt),
        .empty(fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (start) state_d = zero_tile ? DONE : ISSUE;
            ISSUE: if (gnt_ok && last_col && last_row) state_d = DRAIN;
            DRAIN: if (last_pop) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            desc_q    <= '0;
            col_q     <= '0;
            row_q     <= '0;
            row_off_q <= '0;
            outst_q   <= '0;
            total_q   <= '0;
            deliv_q   <= '0;
            pend_q    <= 1'b0;
            done_q    <= 1'b0;
            r_valid_q <= 1'b0;
            r_value_q <= '0;
        end else begin
            done_q    <= (state_q == DONE);
            r_valid_q <= pop;
            if (pop) r_value_q <= fifo_head;
            outst_q <= outst_q + CW'(gnt_ok) - CW'(rv_ok);
            if (start_ok) begin
                desc_q <= '{
                    base_addr:  FM_ADDR_W'(base_addr),
                    row_len:    row_len,
                    n_rows:     n_rows,
                    row_stride: FM_ADDR_W'(row_stride)
                };
                col_q     <= '0;
                row_q     <= '0;
                row_off_q <= '0;
                total_q   <= {8'd0, row_len} * {8'd0, n_rows};
                deliv_q   <= '0;
                pend_q    <= 1'b0;
            end else begin
                if (gnt_ok) begin
                    if (last_col) begin
                        col_q     <= '0;
                        row_q     <= row_q + 8'd1;
                        row_off_q <= row_off_q +
                                     ADDR_W'(desc_q.row_stride);
                    end else begin
                        col_q <= col_q + 8'd1;
                    end
                end
                if (pop) deliv_q <= deliv_q + 16'd1;
                pend_q <= svc && !pop;
            end
        end
    end

`ifdef FM_FETCH_ERR_EN
    logic err_q, err_ev;

    assign err_ev = (start && (state_q != IDLE)) ||
                    (r_req && pend_q) ||
                    (r_req && (!active || deliv_q == total_q)) ||
                    (mem_rvalid && (outst_q == '0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)          err_q <= 1'b0;
        else if (start_ok) err_q <= 1'b0;
        else               err_q <= err_q | err_ev;
    end

    assign err = err_q;
`endif

endmodule

// File: doc/fm_fetch_unit.md
Name: fm_fetch_unit

Overview:
- Upstream stage of the inverted residual block: serves its single-word r_req/r_valid/r_value read handshake from external feature-map memory.
- Walks a 2-D tile (n_rows rows of row_len consecutive words, rows row_stride apart) starting at base_addr.
- Prefetches through a small in-order FIFO so each r_req is answered with minimum latency.

Parameters:
- DATA_W, 16, word width; must match r_value of the consumer.
- ADDR_W, 20, external word-address width.
- FIFO_DEPTH, 4, prefetch FIFO entries; power of 2, minimum 2.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  reset; asynchronous, active-low (rst = 0 resets).
- start  in  1  1-cycle pulse; latches tile descriptor and begins the fetch.
- base_addr  in  ADDR_W  first word address.
- row_len  in  8  words per row.
- n_rows  in  8  rows in the tile.
- row_stride  in  ADDR_W  address increment between row starts.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  1-cycle pulse after the last word is delivered.
- r_req  in  1  1-cycle pulse from the consumer requesting one word.
- r_valid  out  1  1-cycle pulse; r_value is valid in the same cycle.
- r_value  out  DATA_W  delivered word; held until the next delivery.
- mem_req  out  1  memory read request.
- mem_addr  out  ADDR_W  read address; stable while mem_req=1 and mem_gnt=0.
- mem_gnt  in  1  request accepted in this cycle.
- mem_rvalid  in  1  read data valid; returns in order, 1 or more cycles after grant.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- Reset values: busy=0, done=0, r_valid=0, r_value=0, mem_req=0, mem_addr=0, err=0. All counters, the FIFO and the pending flag are cleared; the FSM goes to IDLE.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - start with row_len=0 or n_rows=0 -> DONE. No memory traffic.
  - Otherwise, start -> ISSUE. Latch the descriptor and set col=0, row=0, row_base=base_addr.
- ISSUE:
  - mem_req=1 when fifo_cnt + outstanding < FIFO_DEPTH (credit rule; the FIFO can never overflow).
  - mem_addr = row_base + col, truncated to ADDR_W (wraps modulo 2^ADDR_W).
  - On mem_gnt:
    - outstanding increments.
    - col increments.
    - At col = row_len-1: col=0, row increments, row_base += row_stride.
    - On the grant of the last word (row = n_rows-1 and col = row_len-1) -> DRAIN.
- DRAIN: mem_req=0. When all row_len*n_rows words have been delivered -> DONE.
- DONE: done=1 for one cycle -> IDLE. busy drops in that same cycle.
- mem_rvalid: pushes mem_rdata into the FIFO and decrements outstanding. A grant and an rvalid in the same cycle leave outstanding unchanged.
- Consumer side:
  - A service request is r_req, or a pending flag that is set.
  - If the FIFO is non-empty, pop; r_valid=1 and r_value=head in the next cycle, so r_req at cycle N gives r_valid at N+1.
  - If the FIFO is empty, set the pending flag. It is served the cycle after the data is pushed, so r_valid appears 2 cycles after mem_rvalid.
- At most one pending request is tracked. An r_req while pending is already set is dropped.
- r_req in IDLE, or once all words are delivered: ignored.
- start while busy: ignored.
- mem_rvalid with outstanding=0 (e.g. a stale response after reset mid-operation): discarded.
- Reset mid-operation aborts immediately: no done pulse, and already-fetched FIFO data is lost.

Optional Feature:
- Macro FM_FETCH_ERR_EN.
- When defined: adds output err (1 bit). err is sticky and is set by any of:
  - start while busy.
  - r_req while pending is set.
  - r_req when no words remain.
  - mem_rvalid with outstanding=0.
- err is cleared only by reset or by an accepted start.
- When undefined: no err port. These events are silently ignored as described above.

Decomposition:
- Package fm_fetch_pkg holds:
  - The state enum type (IDLE, ISSUE, DRAIN, DONE).
  - Default DATA_W/ADDR_W/FIFO_DEPTH constants.
  - A tile descriptor struct (base_addr, row_len, n_rows, row_stride).
- One sub-module, fetch_fifo: synchronous FIFO with DATA_W x FIFO_DEPTH storage, push/pop/count, and async active-low reset.

Test Plan:
- Basic tile: base=0x100, row_len=4, n_rows=2, stride=0x10, mem latency 1, consumer pulses r_req every 3 cycles.
  - mem_addr sequence 0x100-0x103 then 0x110-0x113.
  - 8 r_valid pulses carrying the data in order; done one cycle after the 8th; busy low afterwards.
- Credit limit: FIFO_DEPTH=4, consumer idle, 8-word tile.
  - Exactly 4 grants, then mem_req stays 0 until the first pop; the FIFO never overflows.
- Empty FIFO: r_req with mem latency 5 -> pending set; r_valid exactly 2 cycles after mem_rvalid, carrying mem_rdata.
- Zero-size tile: start with row_len=0 -> no mem_req; done pulses 2 cycles after start.
- Reset mid-fetch: rst=0 after 3 grants -> all outputs at reset values. A stale mem_rvalid afterwards produces no r_valid. A new start fetches correctly from base.
- Error flag (FM_FETCH_ERR_EN): a second r_req while pending, or start while busy -> err=1 and held; cleared by the next accepted start.
